// File: rtl/inject_buffer_if.sv
// Handshake bundle between the upstream data selector, the inject buffer and the router.
// The master modport is the selector/router side; the slave modport is the buffer.
interface inject_buffer_if #(
  parameter int unsigned WIDTH = 11
);
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             overflow;

  modport master (
    output in_data,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  full,
    input  overflow
  );

  modport slave (
    input  in_data,
    input  out_ready,
    output out_data,
    output out_valid,
    output full,
    output overflow
  );
endinterface

// File: rtl/inject_buffer.sv
// Edge-detecting packet injection FIFO between a data selector and a router.
// Optional INJECT_COUNT_EN adds a decimal popped-packet counter on a 7-segment digit.
module inject_buffer #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  inject_buffer_if.slave bus
`ifdef INJECT_COUNT_EN
  ,
  output logic [6:0]     hex_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [WIDTH-1:0] pkt_t;

  pkt_t          prev_q;
  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic new_pkt;
  logic push;
  logic pop;
  logic is_full;
  logic not_empty;

  assign is_full   = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);

  // A packet is new when its flag rises or its payload changes while flagged.
  always_comb begin
    new_pkt = bus.in_data[WIDTH-1] &&
              (!prev_q[WIDTH-1] || (bus.in_data[WIDTH-2:0] != prev_q[WIDTH-2:0]));
    pop     = not_empty && bus.out_ready;
    push    = new_pkt && (!is_full || pop);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (new_pkt && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= bus.in_data;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero when nothing is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = not_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;

`ifdef INJECT_COUNT_EN
  logic [3:0] digit_q, digit_d;
  logic [6:0] seg;

  always_comb begin
    digit_d = digit_q;
    if (pop) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= 4'd0;
    else     digit_q <= digit_d;
  end

  // Segments a..g from MSB to LSB, active-high here and inverted at the pin.
  always_comb begin
    seg = 7'b0000000;
    case (digit_q)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  assign hex_count = ~seg;
`endif

endmodule

// File: tb/tb_inject_buffer.sv
// Directed self-checking bench for inject_buffer; builds with or without INJECT_COUNT_EN.
module tb_inject_buffer;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  inject_buffer_if #(.WIDTH(11)) bus ();

`ifdef INJECT_COUNT_EN
  logic [6:0] hex_count;

  inject_buffer #(.WIDTH(11), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .hex_count (hex_count)
  );

  function automatic logic [6:0] hex_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1111110;
      1: s = 7'b0110000;
      2: s = 7'b1101101;
      3: s = 7'b1111001;
      4: s = 7'b0110011;
      5: s = 7'b1011011;
      6: s = 7'b1011111;
      7: s = 7'b1110000;
      8: s = 7'b1111111;
      default: s = 7'b1111011;
    endcase
    return ~s;
  endfunction
`else
  inject_buffer #(.WIDTH(11), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run         = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    check_eq("rst_data", 32'(bus.out_data), 32'h0);
`ifdef INJECT_COUNT_EN
    check_eq("rst_hex", 32'(hex_count), 32'(hex_of(0)));
`endif
    step();
    step();
    rst = 1'b0;

    // Held packet pushes exactly once
    bus.in_data = 11'h405;
    check_eq("hold_pre_valid", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("hold_lat1_valid", 32'(bus.out_valid), 32'd1);
    repeat (9) step();
    check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
    check_eq("hold_full", 32'(bus.full), 32'd0);
    check_eq("hold_data", 32'(bus.out_data), 32'h405);
    bus.out_ready = 1'b1;
    step();
    check_eq("hold_one_entry", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    step();

    // Fill to full, drop the fifth, then drain in order
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = 11'(11'h400 + i);
      step();
      if (i == 3) check_eq("fill3_full", 32'(bus.full), 32'd0);
      if (i == 4) check_eq("fill4_full", 32'(bus.full), 32'd1);
    end
    check_eq("drop_ovf", 32'(bus.overflow), 32'd1);
    check_eq("drop_full", 32'(bus.full), 32'd1);
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_data", 32'(bus.out_data), 32'(11'h400 + i));
      step();
    end
    check_eq("drain_empty", 32'(bus.out_valid), 32'd0);
    check_eq("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b0;

    // Push and pop together while full
    rst = 1'b1;
    #1;
    check_eq("rst2_ovf", 32'(bus.overflow), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 11'(11'h400 + i);
      step();
    end
    check_eq("pp_prefull", 32'(bus.full), 32'd1);
    bus.in_data   = 11'h40A;
    bus.out_ready = 1'b1;
    step();
    check_eq("pp_full", 32'(bus.full), 32'd1);
    check_eq("pp_ovf", 32'(bus.overflow), 32'd0);
    check_eq("pp_head", 32'(bus.out_data), 32'h402);
    bus.in_data = '0;
    check_eq("pp_d0", 32'(bus.out_data), 32'h402);
    step();
    check_eq("pp_d1", 32'(bus.out_data), 32'h403);
    step();
    check_eq("pp_d2", 32'(bus.out_data), 32'h404);
    step();
    check_eq("pp_tail", 32'(bus.out_data), 32'h40A);
    step();
    check_eq("pp_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset with three entries queued
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 11'(11'h410 + i);
      step();
    end
    check_eq("ar_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.in_data = '0;
    #2 rst = 1'b1;
    #1;
    check_eq("ar_valid", 32'(bus.out_valid), 32'd0);
    check_eq("ar_full", 32'(bus.full), 32'd0);
    check_eq("ar_ovf", 32'(bus.overflow), 32'd0);
    check_eq("ar_data", 32'(bus.out_data), 32'h0);
    step();
    bus.out_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ar_no_pop", 32'(bus.out_valid), 32'd0);
    end
    check_eq("ar_empty_full", 32'(bus.full), 32'd0);

    // Flag already high across reset release counts as new
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    bus.in_data   = 11'h415;
    step();
    rst = 1'b0;
    check_eq("rel_pre_valid", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("rel_valid", 32'(bus.out_valid), 32'd1);
    check_eq("rel_data", 32'(bus.out_data), 32'h415);
    bus.out_ready = 1'b1;
    step();
    check_eq("rel_popped", 32'(bus.out_valid), 32'd0);
    bus.in_data = '0;
    step();

    // Flag toggling every two cycles with the router always ready
    for (int k = 0; k < 3; k++) begin
      bus.in_data = 11'h407;
      step();
      check_eq("tog_valid", 32'(bus.out_valid), 32'd1);
      check_eq("tog_data", 32'(bus.out_data), 32'h407);
      step();
      check_eq("tog_single", 32'(bus.out_valid), 32'd0);
      bus.in_data = 11'h000;
      step();
      step();
    end
    check_eq("tog_ovf", 32'(bus.overflow), 32'd0);

    // Eleven packets through; the decimal counter wraps past nine
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef INJECT_COUNT_EN
    check_eq("cnt_hex0", 32'(hex_count), 32'(hex_of(0)));
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.in_data = 11'(11'h420 + i);
      step();
      check_eq("cnt_data", 32'(bus.out_data), 32'(11'h420 + i));
      step();
      check_eq("cnt_valid", 32'(bus.out_valid), 32'd0);
`ifdef INJECT_COUNT_EN
      check_eq("cnt_hex", 32'(hex_count), 32'(hex_of((i + 1) % 10)));
`endif
    end
`ifdef INJECT_COUNT_EN
    check_eq("cnt_hex_final", 32'(hex_count), 32'(~7'b0110000));
`endif
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
